// File: rtl/mem_bus_pkg.sv
// Shared definitions for the word-copy DMA initiator on the softcore memory bus.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        WR_REQ    = 3'd3,
        WR_WAIT   = 3'd4,
        FINISH    = 3'd5
    } dma_state_t;

    localparam logic [3:0]  WMASK_WORD = 4'hF;
    localparam logic [3:0]  WMASK_NONE = 4'h0;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_bus_dma.sv
// Word-copy DMA engine: reads word_count words from src_addr and writes them to
// dst_addr through the RAM controller using the core's strobe/busy handshake.
// One word is in flight at a time; addresses ascend and wrap modulo 2^32.
module mem_bus_dma
    import mem_bus_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wmask,
    output logic             m_rstrb,
    input  logic [31:0]      m_rdata,
    input  logic             m_rbusy,
    input  logic             m_wbusy
);

    // The timer holds the number of busy cycles already spent in the current
    // wait state, so the transaction gives up on the cycle it would reach TIMEOUT.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    dma_state_t       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] wdone_q, wdone_d;
    logic [15:0]      timer_q, timer_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;

    logic [LEN_W-1:0] wdone_inc;
    logic             misaligned;

    assign wdone_inc  = wdone_q + LEN_W'(1);
    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    assign busy       = busy_q;
    assign err        = err_q;
    assign words_done = wdone_q;

    // Job state, pointers and sticky flags; reset drops any job in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            wdone_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            wdone_q <= wdone_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic and bus drive; strobes exist only in the two request states.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        wdone_d = wdone_q;
        timer_d = timer_q;
        err_d   = err_q;
        busy_d  = busy_q;
        abort_d = abort_q;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = WMASK_NONE;
        m_rstrb = 1'b0;
        done    = 1'b0;

        // An abort is remembered until the word in flight has been written.
        if (abort && (state_q inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT})) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    wdone_d = '0;
                    abort_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else if (word_count == '0) begin
                        err_d   = 1'b0;
                        state_d = FINISH;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = word_count;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                m_addr  = src_q;
                m_rstrb = 1'b1;
                timer_d = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                m_addr = src_q;
                if (!m_rbusy) begin
                    data_d  = m_rdata;
                    state_d = WR_REQ;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            WR_REQ: begin
                m_addr  = dst_q;
                m_wdata = data_q;
                m_wmask = WMASK_WORD;
                timer_d = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                m_addr  = dst_q;
                m_wdata = data_q;
                if (!m_wbusy) begin
                    wdone_d = wdone_inc;
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    if ((wdone_inc == cnt_q) || abort_q || abort) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FINISH: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_dma.sv
// Bench for mem_bus_dma: a RAM responder with random wait states and a
// word-level copy model of the expected memory image.
module tb_mem_bus_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_done;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_rstrb;
    logic [31:0] m_rdata;
    logic        m_rbusy;
    logic        m_wbusy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem  [0:1023];
    logic [31:0] refm [0:1023];
    logic [31:0] rlog [$];
    logic [31:0] wlog [$];
    int          max_lat    = 0;
    bit          hold_rbusy = 0;
    bit          hold_wbusy = 0;

    mem_bus_dma #(.LEN_W(16), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wmask    (m_wmask),
        .m_rstrb    (m_rstrb),
        .m_rdata    (m_rdata),
        .m_rbusy    (m_rbusy),
        .m_wbusy    (m_wbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder: acts on strobes seen mid-cycle, then holds busy for a random time.
    initial begin
        int rcnt;
        int wcnt;
        rcnt = 0;
        wcnt = 0;
        m_rbusy = 1'b0;
        m_wbusy = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_rstrb) begin
                rlog.push_back(m_addr);
                m_rdata = mem[m_addr[11:2]];
                rcnt = $urandom_range(0, max_lat);
            end else if (rcnt > 0) begin
                rcnt--;
            end
            if (m_wmask == 4'hF) begin
                wlog.push_back(m_addr);
                mem[m_addr[11:2]] = m_wdata;
                wcnt = $urandom_range(0, max_lat);
            end else if (wcnt > 0) begin
                wcnt--;
            end
            m_rbusy = hold_rbusy || (rcnt > 0);
            m_wbusy = hold_wbusy || (wcnt > 0);
        end
    end

    // Reference: sequential ascending word copy on a snapshot of memory.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa;
        logic [31:0] da;
        for (int i = 0; i < 1024; i++) refm[i] = mem[i];
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            refm[da[11:2]] = refm[sa[11:2]];
        end
    endtask

    function automatic int mem_diffs();
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== refm[i]) bad++;
        return bad;
    endfunction

    // Issue one start pulse and observe the bus until two cycles past done.
    // Cycle 0 is the cycle in which start is presented to the DUT.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int abort_at, output int done_cyc, output int n_done,
                           output int n_rd, output int n_wr, output int first_rd,
                           output int busy_hi, output int overlap);
        bit aborting;
        n_done = 0; n_rd = 0; n_wr = 0; done_cyc = -1; first_rd = -1;
        busy_hi = 0; overlap = 0; aborting = 0;
        rlog.delete();
        wlog.delete();
        @(posedge clk); #1;
        src_addr = s;
        dst_addr = d;
        word_count = n[15:0];
        start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (aborting) begin
                abort = 1'b0;
                aborting = 0;
            end
            if (m_rstrb) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
                if (abort_at != 0 && n_rd == abort_at) begin
                    abort = 1'b1;
                    aborting = 1;
                end
            end
            if (m_wmask != 4'h0) n_wr++;
            if (m_rstrb && m_wmask != 4'h0) overlap++;
            if (busy) busy_hi++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, err, words_done, m_addr, m_wdata, m_wmask, m_rstrb} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b wd=%0d addr=%h wdata=%h wmask=%h rstrb=%0b, required all 0",
                     busy, done, err, words_done, m_addr, m_wdata, m_wmask, m_rstrb);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, err, m_wmask, m_rstrb} !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b err=%0b wmask=%h rstrb=%0b, required 0",
                     busy, done, err, m_wmask, m_rstrb);
        end
    endtask

    task automatic test_basic();
        int dc, nd, nr, nw, fr, bh, ov;
        max_lat = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h11111111 * (i + 1);
        model_copy(32'h0, 32'h100, 4);
        run_job(32'h0, 32'h100, 4, 0, dc, nd, nr, nw, fr, bh, ov);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem[64 + i] !== 32'h11111111 * (i + 1)) begin
                tests_failed++;
                $display("FAIL basic_dst_word%0d: got %h, required %h", i, mem[64 + i], 32'h11111111 * (i + 1));
            end
        end
        tests_run++;
        if (words_done !== 16'd4 || err !== 1'b0 || nd != 1) begin
            tests_failed++;
            $display("FAIL basic_status: words_done=%0d err=%0b done_pulses=%0d, required 4/0/1", words_done, err, nd);
        end
        tests_run++;
        if (nr != 4 || nw != 4 || ov != 0) begin
            tests_failed++;
            $display("FAIL basic_strobes: rstrb=%0d wmask=%0d overlap=%0d, required 4/4/0", nr, nw, ov);
        end
        // Start cycle through done cycle inclusive is 4N+2 = 18 cycles.
        tests_run++;
        if (dc != 17) begin
            tests_failed++;
            $display("FAIL basic_latency: done in cycle %0d, required 17", dc);
        end
    endtask

    task automatic test_random_copies();
        int dc, nd, nr, nw, fr, bh, ov, n, bad;
        logic [31:0] s, d;
        for (int t = 0; t < 8; t++) begin
            max_lat = $urandom_range(0, 3);
            s = $urandom & 32'hFFFF_FFFC;
            d = (t % 2 == 0) ? (s + 32'(4 * $urandom_range(0, 6))) : ($urandom & 32'hFFFF_FFFC);
            n = $urandom_range(1, 8);
            model_copy(s, d, n);
            run_job(s, d, n, 0, dc, nd, nr, nw, fr, bh, ov);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (i >= rlog.size() || rlog[i] !== s + 32'(4 * i)) bad++;
                if (i >= wlog.size() || wlog[i] !== d + 32'(4 * i)) bad++;
            end
            tests_run++;
            if (mem_diffs() != 0 || bad != 0) begin
                tests_failed++;
                $display("FAIL random_copy%0d: mem_diffs=%0d addr_errs=%0d (s=%h d=%h n=%0d), required 0/0",
                         t, mem_diffs(), bad, s, d, n);
            end
            tests_run++;
            if (words_done !== 16'(n) || err !== 1'b0 || nd != 1 || nr != n || nw != n || ov != 0) begin
                tests_failed++;
                $display("FAIL random_status%0d: wd=%0d err=%0b done=%0d rd=%0d wr=%0d ov=%0d, required %0d/0/1/%0d/%0d/0",
                         t, words_done, err, nd, nr, nw, ov, n, n, n);
            end
        end
    endtask

    task automatic test_zero_len();
        int dc, nd, nr, nw, fr, bh, ov;
        run_job(32'h10, 32'h200, 0, 0, dc, nd, nr, nw, fr, bh, ov);
        tests_run++;
        if (dc != 1 || nd != 1 || bh != 0 || nr != 0 || nw != 0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len: done_cyc=%0d done=%0d busy_cycles=%0d rd=%0d wr=%0d err=%0b, required 1/1/0/0/0/0",
                     dc, nd, bh, nr, nw, err);
        end
    endtask

    task automatic test_misaligned();
        int dc, nd, nr, nw, fr, bh, ov;
        run_job(32'h2, 32'h100, 4, 0, dc, nd, nr, nw, fr, bh, ov);
        tests_run++;
        if (err !== 1'b1 || nd != 1 || dc != 1 || nr != 0 || nw != 0) begin
            tests_failed++;
            $display("FAIL misaligned: err=%0b done=%0d done_cyc=%0d rd=%0d wr=%0d, required 1/1/1/0/0", err, nd, dc, nr, nw);
        end
        max_lat = 2;
        model_copy(32'h0, 32'h300, 1);
        run_job(32'h0, 32'h300, 1, 0, dc, nd, nr, nw, fr, bh, ov);
        tests_run++;
        if (err !== 1'b0 || nd != 1 || words_done !== 16'd1 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL err_cleared: err=%0b done=%0d wd=%0d mem_diffs=%0d, required 0/1/1/0", err, nd, words_done, mem_diffs());
        end
    endtask

    task automatic test_abort();
        int dc, nd, nr, nw, fr, bh, ov;
        max_lat = 1;
        model_copy(32'h40, 32'h800, 3);
        run_job(32'h40, 32'h800, 8, 3, dc, nd, nr, nw, fr, bh, ov);
        tests_run++;
        if (nw != 3 || words_done !== 16'd3 || err !== 1'b0 || nd != 1 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL abort: writes=%0d wd=%0d err=%0b done=%0d mem_diffs=%0d, required 3/3/0/1/0",
                     nw, words_done, err, nd, mem_diffs());
        end
    endtask

    task automatic test_timeout();
        int dc, nd, nr, nw, fr, bh, ov;
        max_lat = 0;
        hold_rbusy = 1;
        run_job(32'h0, 32'h100, 4, 0, dc, nd, nr, nw, fr, bh, ov);
        hold_rbusy = 0;
        tests_run++;
        if (err !== 1'b1 || nd != 1 || words_done !== 16'd0 || nw != 0 || nr != 1) begin
            tests_failed++;
            $display("FAIL timeout_status: err=%0b done=%0d wd=%0d wr=%0d rd=%0d, required 1/1/0/0/1", err, nd, words_done, nw, nr);
        end
        // RD_WAIT is entered the cycle after the strobe; done follows 16 cycles later.
        tests_run++;
        if (dc - fr != 17) begin
            tests_failed++;
            $display("FAIL timeout_latency: done %0d cycles after strobe, required 17", dc - fr);
        end
    endtask

    task automatic test_wrap();
        int dc, nd, nr, nw, fr, bh, ov;
        logic [31:0] r0, r1;
        max_lat = 1;
        mem[1023] = 32'hCAFE_0001;
        mem[0]    = 32'hCAFE_0002;
        model_copy(32'hFFFF_FFFC, 32'h400, 2);
        run_job(32'hFFFF_FFFC, 32'h400, 2, 0, dc, nd, nr, nw, fr, bh, ov);
        r0 = (rlog.size() > 0) ? rlog[0] : 32'hDEAD_BEEF;
        r1 = (rlog.size() > 1) ? rlog[1] : 32'hDEAD_BEEF;
        tests_run++;
        if (r0 !== 32'hFFFF_FFFC || r1 !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_addr: reads %h,%h, required fffffffc,00000000", r0, r1);
        end
        tests_run++;
        if (mem_diffs() != 0 || words_done !== 16'd2 || nd != 1) begin
            tests_failed++;
            $display("FAIL wrap_copy: mem_diffs=%0d wd=%0d done=%0d, required 0/2/1", mem_diffs(), words_done, nd);
        end
    endtask

    task automatic test_reset_mid();
        int dc, nd, nr, nw, fr, bh, ov;
        bit seen;
        max_lat = 0;
        hold_wbusy = 1;
        seen = 0;
        @(posedge clk); #1;
        src_addr = 32'h60; dst_addr = 32'h500; word_count = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_wmask == 4'hF) begin
                seen = 1;
                break;
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (!seen || busy !== 1'b1 || m_addr !== 32'h500) begin
            tests_failed++;
            $display("FAIL reset_mid_setup: wmask_seen=%0b busy=%0b addr=%h, required 1/1/00000500", seen, busy, m_addr);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, err, words_done, m_addr, m_wdata, m_wmask, m_rstrb} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: busy=%0b done=%0b err=%0b wd=%0d addr=%h wdata=%h wmask=%h rstrb=%0b, required all 0",
                     busy, done, err, words_done, m_addr, m_wdata, m_wmask, m_rstrb);
        end
        hold_wbusy = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_copy(32'h20, 32'h600, 1);
        run_job(32'h20, 32'h600, 1, 0, dc, nd, nr, nw, fr, bh, ov);
        tests_run++;
        if (dc != 5 || nd != 1 || words_done !== 16'd1 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL after_reset_job: done_cyc=%0d done=%0d wd=%0d mem_diffs=%0d, required 5/1/1/0",
                     dc, nd, words_done, mem_diffs());
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_count = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_random_copies();
        test_zero_len();
        test_misaligned();
        test_abort();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_dma.md
Name: mem_bus_dma

Overview:
- Word-copy DMA engine; an initiator (bus master) on the same 32-bit memory bus that the softcore drives into the RAM controller.
- Copies `word_count` 32-bit words from `src_addr` to `dst_addr` through the controller, using the same strobe/busy handshake as the core.
- Sits beside the softcore behind a bus mux (mux not in scope); gives PIM-side logic bulk data movement without CPU loads/stores.

Parameters:
- LEN_W, 16, width of word_count and words_done
- TIMEOUT, 255, max cycles one bus transaction may stay busy before err; range 1..65535

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches src_addr/dst_addr/word_count when idle
- abort  input  1  stop after the current bus transaction completes
- src_addr  input  32  source byte address, word-aligned
- dst_addr  input  32  destination byte address, word-aligned
- word_count  input  LEN_W  number of words to copy
- busy  output  1  high from accepted start until done pulse
- done  output  1  one-cycle pulse at end (success, abort or error)
- err  output  1  sticky error flag; cleared by the next accepted start
- words_done  output  LEN_W  words fully written so far in the current job
- m_addr  output  32  bus address
- m_wdata  output  32  bus write data
- m_wmask  output  4  byte write mask; 4'hF for one cycle launches a write
- m_rstrb  output  1  one-cycle read strobe
- m_rdata  input  32  bus read data
- m_rbusy  input  1  responder busy reading
- m_wbusy  input  1  responder busy writing

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, done=0, err=0, words_done=0, m_addr=0, m_wdata=0, m_wmask=0, m_rstrb=0; internal pointers, count and timer cleared.
- Reset mid-job drops the job immediately. No recovery of a partially completed write is attempted.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE:
  - start=1 with src_addr[1:0]!=0 or dst_addr[1:0]!=0 → err=1, go to FINISH; no bus traffic.
  - start=1 with word_count=0 → go to FINISH, err=0; no bus traffic.
  - Otherwise latch the job, clear words_done and err, busy=1, go to RD_REQ.
- start while busy: ignored.
- RD_REQ: m_addr=src pointer, m_rstrb=1 for exactly this cycle; next state RD_WAIT.
- RD_WAIT: m_addr held stable. On the first cycle with m_rbusy=0, capture m_rdata into the data register and go to WR_REQ. The earliest capture is the cycle after the strobe.
- WR_REQ: m_addr=dst pointer, m_wdata=data register, m_wmask=4'hF for exactly this cycle; next state WR_WAIT.
- WR_WAIT: m_addr and m_wdata held stable. On the first cycle with m_wbusy=0:
  - words_done++, src+=4, dst+=4, both wrapping modulo 2^32.
  - If words_done (new value) = count or abort is pending → FINISH; else → RD_REQ.
- FINISH: done=1 for one cycle, busy=0 from the next cycle; next state IDLE.
- Abort:
  - Sampled in any busy state and held pending until WR_WAIT completes.
  - Abort during a read still completes that word's write.
  - err is not set by abort.
- Timeout:
  - Timer resets on entry to RD_WAIT/WR_WAIT and counts while waiting.
  - Reaching TIMEOUT → err=1, m_wmask/m_rstrb=0, go to FINISH; words_done is not incremented.
- m_rstrb and m_wmask are never asserted in the same cycle. Both are 0 outside RD_REQ/WR_REQ.
- Throughput with a zero-wait responder is 4 cycles per word. Latency from start to done is 4N+2 cycles.
- Overlapping src/dst ranges copy strictly ascending; no overlap correction.

Decomposition:
- Shared package mem_bus_pkg:
  - dma_state_t enum
  - WMASK_WORD = 4'hF, WMASK_NONE = 4'h0
  - WORD_BYTES = 4
- Single module; the timeout counter stays inline. No sub-module.

Test Plan:
- Basic copy: preload RAM words 0x00..0x0C with 0x11111111..0x44444444; start src=0x0, dst=0x100, count=4 → dst words match, words_done=4, done pulses once, err=0, exactly 4 rstrb and 4 wmask pulses.
- Zero length: count=0 → done one cycle after start, busy never high, no bus strobes.
- Misaligned: src=0x2 → err=1 with done, no bus traffic. A following valid start clears err.
- Abort: count=8, abort asserted during the 3rd read → exactly 3 words written, words_done=3, err=0.
- Timeout: TIMEOUT=16, responder holds m_rbusy=1 forever → err=1 and done 16 cycles after RD_WAIT entry, words_done=0.
- Wrap and reset: src=0xFFFFFFFC with count=2 → second read address 0x00000000. Separately, reset asserted mid-WR_WAIT → all outputs 0 the same cycle, FSM returns to IDLE.
